sat_addsub_pipe: RTL and testbench
==================================

// Module: sat_addsub_pipe
// PURPOSE
//  Parametrised, pipelined saturating/wrapping two's-complement add/sub unit for the Execute stage.
//  It generalises the 16-bit CLA add/sub with these additions:
//  - WIDTH and latency are parameters.
//  - Per-op mode select: saturate or wrap.
//  - valid/ready handshake with backpressure.
//  - N/Z/V flags per result, plus a sticky overflow flag.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=4)
//  STAGES  2   pipeline depth = latency in cycles from accept to out_valid (1..4)
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      unit can accept a beat this cycle
//  a           in   WIDTH  operand A, signed
//  b           in   WIDTH  operand B, signed
//  op          in   2      00 add-sat, 01 sub-sat, 10 add-wrap, 11 sub-wrap
//  out_valid   out  1      result beat valid
//  out_ready   in   1      consumer accepts result this cycle
//  result      out  WIDTH  signed result
//  flag_v      out  1      overflow occurred (before saturation)
//  flag_n      out  1      result[WIDTH-1]
//  flag_z      out  1      result == 0
//  ovf_sticky  out  1      set by any accepted result with flag_v=1
//  clr_sticky  in   1      clears ovf_sticky
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): all stage valids, out_valid, result, flags and ovf_sticky <= 0.
//    Reset mid-operation drops every in-flight beat. No beat is emitted for it.
//  - Accept: a beat is accepted when in_valid && in_ready.
//  - Output handshake: a beat is delivered when out_valid && out_ready.
//  - Arithmetic: sub computes a + ~b + 1. The raw sum is WIDTH bits, modulo 2^WIDTH.
//  - Overflow:
//    - add: a[MSB]==b[MSB] and raw[MSB]!=a[MSB].
//    - sub: a[MSB]!=b[MSB] and raw[MSB]!=a[MSB].
//  - Saturate modes (op[1]=0), on overflow:
//    - a[MSB]=0: result = 0111..1 (max positive).
//    - a[MSB]=1: result = 1000..0 (min negative).
//    - Otherwise result = raw.
//  - Wrap modes (op[1]=1): result = raw always. flag_v still reports overflow.
//  - flag_n and flag_z are taken from the final (post-saturation) result.
//  - Pipeline:
//    - Stage 1 registers the computed result and flags.
//    - Stages 2..STAGES are delay registers, each with its own valid bit.
//    - Latency with no stalls is exactly STAGES cycles.
//    - Throughput is 1 beat/cycle.
//  - Stall rule:
//    - Stage k advances iff stage k+1 is empty or advancing.
//    - The last stage advances iff out_ready.
//    - in_ready = stage1 empty || stage1 advancing (combinational; no bubble when out_ready stays 1).
//  - Stalled beats hold result and flags stable until delivered.
//    Beats are never dropped, duplicated or reordered.
//  - Capacity: STAGES beats in flight.
//    With out_ready held 0, in_ready falls after STAGES beats are accepted.
//  - Sticky flag:
//    - ovf_sticky <= 1 on a delivered beat with flag_v=1.
//    - clr_sticky clears it next cycle.
//    - Same-cycle clear and set: set wins (ovf_sticky=1).
//  - result, flags and ovf_sticky are registered outputs. Values while out_valid=0 are don't-care.
// TESTING (WIDTH=16, STAGES=2 unless noted)
//  1. a=0x7000, b=0x1000, op=00 -> result 0x7FFF, v=1, n=0, 2 cycles after accept.
//     Same operands with op=10 -> 0x8000, v=1, n=1.
//  2. a=0x8000, b=0x0001, op=01 -> 0x8000, v=1.
//     a=0x7FFF, b=0xFFFF, op=01 -> 0x7FFF, v=1.
//     a=0x0005, b=0x0005, op=01 -> 0x0000, z=1, v=0.
//  3. Backpressure: out_ready=0, push 3 beats.
//     -> in_ready=0 after beat 2; first result held stable.
//     Raise out_ready -> beats emerge in order, one per cycle.
//  4. Streaming: 512 random beats with out_ready=1.
//     -> one result per cycle; each equals a golden model (sat/wrap) with exact flags.
//  5. Sticky: overflow beat delivered -> ovf_sticky=1.
//     clr_sticky in the same cycle another ovf beat is delivered -> stays 1.
//     Lone clr_sticky -> 0.
//  6. rst=1 for one cycle with 2 beats in flight -> out_valid=0 next cycle and no stale beat later.
//     Repeat tests 1 and 4 with WIDTH=8, STAGES=1 and STAGES=4 (latency 1 and 4).

Source files
------------

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: pipelined saturating/wrapping two's-complement add/sub with valid/ready flow control
module sat_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);
    logic [WIDTH-1:0] raw, sat, res;
    logic ovf;
    logic [WIDTH+3:0] stg_in;
    logic [STAGES-1:0][WIDTH+3:0] stg;
    logic [STAGES:0][WIDTH+3:0] chain;
    logic [STAGES:0] go;
    always_comb begin
        raw = op[0] ? a + ~b + WIDTH'(1) : a + b;
        ovf = (op[0] ? a[WIDTH-1] != b[WIDTH-1] : a[WIDTH-1] == b[WIDTH-1]) && raw[WIDTH-1] != a[WIDTH-1];
        sat = {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}};
        res = (ovf && !op[1]) ? sat : raw;
    end
    // stage word: {valid, v, n, z, result}
    assign stg_in = {in_valid, ovf, res[WIDTH-1], res == '0, res};
    assign chain  = {stg, stg_in};
    always_comb begin
        go[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) go[i] = !stg[i][WIDTH+3] || go[i+1];
    end
    always_ff @(posedge clk) begin
        if (rst) stg <= '0;
        else for (int i = 0; i < STAGES; i++) if (go[i]) stg[i] <= chain[i];
    end
    always_ff @(posedge clk) begin
        if (rst) ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && flag_v) ovf_sticky <= 1'b1;
        else if (clr_sticky) ovf_sticky <= 1'b0;
    end
    assign in_ready = go[0];
    assign {out_valid, flag_v, flag_n, flag_z, result} = stg[STAGES-1];
endmodule

// File: tb/tb_sat_addsub_pipe.sv
// tb_sat_addsub_pipe: vector table plus queue scoreboard for three configurations of the add/sub pipe
module tb_sat_addsub_pipe;
    typedef struct {
        logic [15:0] r;
        logic v, n, z;
        int cyc;
    } exp_t;
    typedef struct {
        logic [15:0] a, b;
        logic [1:0] op;
        logic [15:0] r;
        logic v, n, z;
    } vec_t;

    logic clk = 0, rst = 1;
    logic in_valid = 0, out_ready = 1, clr_sticky = 0;
    logic [15:0] a = 0, b = 0;
    logic [1:0] op = 0;
    logic in_ready, out_valid, flag_v, flag_n, flag_z, ovf_sticky;
    logic [15:0] result;

    logic sv = 0;
    logic [7:0] sa = 0, sb = 0;
    logic [1:0] sop = 0;
    logic in_ready1, out_valid1, v1, n1, z1, st1;
    logic in_ready4, out_valid4, v4, n4, z4, st4;
    logic [7:0] result1, result4;

    int total = 0, bad = 0, cyc = 0, n_del = 0;
    bit lat_chk = 0;
    exp_t q[$], q1[$], q4[$];
    exp_t pend, pend8;
    vec_t vt[12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sat_addsub_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag_v(flag_v),
        .flag_n(flag_n), .flag_z(flag_z), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky));

    sat_addsub_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(in_ready1), .a(sa), .b(sb), .op(sop),
        .out_valid(out_valid1), .out_ready(1'b1), .result(result1), .flag_v(v1),
        .flag_n(n1), .flag_z(z1), .ovf_sticky(st1), .clr_sticky(1'b0));

    sat_addsub_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(in_ready4), .a(sa), .b(sb), .op(sop),
        .out_valid(out_valid4), .out_ready(1'b1), .result(result4), .flag_v(v4),
        .flag_n(n4), .flag_z(z4), .ovf_sticky(st4), .clr_sticky(1'b0));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic v, input logic n, input logic z);
        exp_t e;
        e.r = r; e.v = v; e.n = n; e.z = z; e.cyc = 0;
        return e;
    endfunction

    // integer reference: exact signed sum, then clamp or truncate
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o, input int w);
        longint mask, mx, mn, sx, sy, s;
        exp_t e;
        mask = (longint'(1) << w) - 1;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -mx - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (sx > mx) sx -= mask + 1;
        if (sy > mx) sy -= mask + 1;
        s = o[0] ? sx - sy : sx + sy;
        e.v = s > mx || s < mn;
        if (!o[1] && e.v) s = (s > mx) ? mx : mn;
        e.r = 16'(s & mask);
        e.n = e.r[w-1];
        e.z = e.r == 16'h0;
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (out_valid && out_ready) begin
                n_del++;
                if (q.size() == 0) chk("w16s2_unexpected_beat", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("w16s2_result", {result, flag_v, flag_n, flag_z}, {e.r, e.v, e.n, e.z});
                    if (lat_chk) chk("w16s2_latency", cyc - e.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = pend; e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) q1.delete();
        else begin
            if (out_valid1) begin
                if (q1.size() == 0) chk("w8s1_unexpected_beat", 1, 0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("w8s1_result", {result1, v1, n1, z1}, {e.r[7:0], e.v, e.n, e.z});
                    chk("w8s1_latency", cyc - e.cyc, 1);
                end
            end
            if (sv && in_ready1) begin
                exp_t e;
                e = pend8; e.cyc = cyc;
                q1.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) q4.delete();
        else begin
            if (out_valid4) begin
                if (q4.size() == 0) chk("w8s4_unexpected_beat", 1, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("w8s4_result", {result4, v4, n4, z4}, {e.r[7:0], e.v, e.n, e.z});
                    chk("w8s4_latency", cyc - e.cyc, 4);
                end
            end
            if (sv && in_ready4) begin
                exp_t e;
                e = pend8; e.cyc = cyc;
                q4.push_back(e);
            end
        end
    end

    task automatic wait_acc();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o, input exp_t e);
        a = x; b = y; op = o; pend = e; in_valid = 1;
        wait_acc();
    endtask

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o, input exp_t e);
        int n = 0;
        sa = x; sb = y; sop = o; pend8 = e; sv = 1;
        @(negedge clk);
        while (!(in_ready1 && in_ready4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(in_ready1 && in_ready4)) chk("accept8_timeout", 0, 1);
        @(posedge clk);
        #1 sv = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() + q1.size() + q4.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_empty", q.size() + q1.size() + q4.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] x, y;
        logic [1:0] o;
        vt[0]  = '{16'h7000, 16'h1000, 2'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{16'h7000, 16'h1000, 2'd2, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{16'h8000, 16'h0001, 2'd1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{16'h7FFF, 16'hFFFF, 2'd1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{16'h0005, 16'h0005, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{16'h8000, 16'h8000, 2'd0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{16'h8000, 16'h8000, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{16'h1234, 16'h0001, 2'd3, 16'h1233, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{16'h0000, 16'h8000, 2'd1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vt[10] = '{16'h0000, 16'h8000, 2'd3, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[11] = '{16'hFFFE, 16'h0003, 2'd2, 16'h0001, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_state", {out_valid, in_ready, result, flag_v, flag_n, flag_z, ovf_sticky},
            {1'b0, 1'b1, 16'h0, 4'b0});
        chk("reset_small", {out_valid1, out_valid4, in_ready1, in_ready4, st1, st4}, 6'b001100);
        @(posedge clk);
        #1;

        lat_chk = 1;
        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].op, mk(vt[i].r, vt[i].v, vt[i].n, vt[i].z));
        drain();
        chk("sticky_after_vectors", ovf_sticky, 1);

        // backpressure: two beats fill the pipe, a third waits
        lat_chk = 0;
        out_ready = 0;
        send(vt[0].a, vt[0].b, vt[0].op, mk(vt[0].r, vt[0].v, vt[0].n, vt[0].z));
        send(vt[2].a, vt[2].b, vt[2].op, mk(vt[2].r, vt[2].v, vt[2].n, vt[2].z));
        a = vt[4].a; b = vt[4].b; op = vt[4].op;
        pend = mk(vt[4].r, vt[4].v, vt[4].n, vt[4].z);
        in_valid = 1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_head_valid", out_valid, 1);
        chk("bp_head_result", result, 16'h7FFF);
        repeat (2) @(negedge clk);
        chk("bp_head_stable", {result, flag_v, flag_n, flag_z}, {16'h7FFF, 3'b100});
        chk("bp_in_ready_still_low", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
        n = n_del;
        wait_acc();
        repeat (2) @(posedge clk);
        #1 chk("bp_one_per_cycle", n_del - n, 3);
        drain();

        // sticky: clear while an overflow beat is stalled, then clear and set together, then lone clear
        out_ready = 0;
        send(vt[2].a, vt[2].b, vt[2].op, mk(vt[2].r, vt[2].v, vt[2].n, vt[2].z));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("sticky_stall_valid", out_valid, 1);
        clr_sticky = 1;
        @(posedge clk);
        #1 clr_sticky = 0;
        chk("sticky_cleared_stalled", {ovf_sticky, out_valid}, 2'b01);
        out_ready = 1;
        clr_sticky = 1;
        @(posedge clk);
        #1 clr_sticky = 0;
        chk("sticky_set_wins", ovf_sticky, 1);
        clr_sticky = 1;
        @(posedge clk);
        #1 clr_sticky = 0;
        chk("sticky_lone_clear", ovf_sticky, 0);
        send(vt[7].a, vt[7].b, vt[7].op, mk(vt[7].r, vt[7].v, vt[7].n, vt[7].z));
        drain();
        chk("sticky_no_ovf_stays_low", ovf_sticky, 0);

        // reset with two overflow beats in flight
        send(vt[0].a, vt[0].b, vt[0].op, mk(vt[0].r, vt[0].v, vt[0].n, vt[0].z));
        send(vt[5].a, vt[5].b, vt[5].op, mk(vt[5].r, vt[5].v, vt[5].n, vt[5].z));
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        n = n_del;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sticky", ovf_sticky, 0);
        repeat (6) @(posedge clk);
        #1 chk("rst_mid_no_stale", n_del - n, 0);

        // random streaming against the integer model
        lat_chk = 1;
        n = n_del;
        for (int i = 0; i < 512; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            o = 2'($urandom);
            if ($urandom_range(0, 3) == 0) x = {x[15], {15{~x[15]}}};
            if ($urandom_range(0, 3) == 0) y = {y[15], {15{~y[15]}}};
            send(x, y, o, model(x, y, o, 16));
        end
        drain();
        chk("stream_count", n_del - n, 512);

        // 8-bit configurations with latency 1 and 4
        send8(8'h70, 8'h10, 2'd0, mk(16'h007F, 1'b1, 1'b0, 1'b0));
        send8(8'h70, 8'h10, 2'd2, mk(16'h0080, 1'b1, 1'b1, 1'b0));
        send8(8'h80, 8'h01, 2'd1, mk(16'h0080, 1'b1, 1'b1, 1'b0));
        send8(8'h05, 8'h05, 2'd1, mk(16'h0000, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom_range(0, 255));
            y = 16'($urandom_range(0, 255));
            o = 2'($urandom);
            if ($urandom_range(0, 3) == 0) x[7:0] = {x[7], {7{~x[7]}}};
            send8(x[7:0], y[7:0], o, model(x, y, o, 8));
        end
        drain();
        chk("small_sticky_set", {st1, st4}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
